// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data_ram arbiter:
// owner states, master ids, wait counter width.
package arb_defs;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_e;

endpackage

// File: rtl/data_ram_arbiter_wait_cnt.sv
// Per-master consecutive-denial counter,
// saturating at limit; clears on grant or idle.
module arb_wait_cnt
  import arb_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             gnt,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count >= limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (req && !gnt) begin
      if (!at_max) count <= count + CNT_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master data_ram arbiter with m1 bus lock and starvation limit.
// Define ARB_ROUND_ROBIN_EN for round-robin ties (else m0 wins ties).
module data_ram_arbiter
  import arb_defs::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_ce,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_sel,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_gnt,
  input  logic          m1_ce,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_sel,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_gnt,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_sel,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(WAIT_MAX);

  own_e             state;
  mid_e             last;
  logic [CNT_W-1:0] w0;
  logic [CNT_W-1:0] w1;
  logic             max0;
  logic             max1;
  logic             gnt0;
  logic             gnt1;
  logic             hold;
  logic             tie1;

  arb_wait_cnt u_wait0 (
    .clk    (clk),
    .rst    (rst),
    .req    (m0_ce),
    .gnt    (gnt0),
    .limit  (LIMIT),
    .count  (w0),
    .at_max (max0)
  );

  arb_wait_cnt u_wait1 (
    .clk    (clk),
    .rst    (rst),
    .req    (m1_ce),
    .gnt    (gnt1),
    .limit  (LIMIT),
    .count  (w1),
    .at_max (max1)
  );

  always_comb begin
    assert (w0 <= LIMIT && w1 <= LIMIT);
  end

  // Items after the single-request ones only see both masters requesting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    hold = (state == OWN1) && m1_ce && !max0;
    tie1 = RR_EN && (last == M0);
    priority case (1'b1)
      hold:               gnt1 = 1'b1;
      (m0_ce && !m1_ce):  gnt0 = 1'b1;
      (m1_ce && !m0_ce):  gnt1 = 1'b1;
      (m0_ce && max0):    gnt0 = 1'b1;
      (m1_ce && max1):    gnt1 = 1'b1;
      m0_ce: begin
        gnt1 = tie1;
        gnt0 = !tie1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= M1;
    end else begin
      if (gnt0 || gnt1) last <= gnt1 ? M1 : M0;
      unique case (state)
        IDLE: begin
          if (gnt0)                 state <= OWN0;
          else if (gnt1 && m1_lock) state <= OWN1;
        end
        OWN0: begin
          if (!gnt0) state <= IDLE;
        end
        OWN1: begin
          if (!m1_ce || !m1_lock) state <= IDLE;
          else if (gnt0)          state <= OWN0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ce    = gnt0 | gnt1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
      m0_rdata  = ram_rdata;
    end else if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
      m1_rdata  = ram_rdata;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus
// random traffic against a rule-level reference model.
module tb_data_ram_arbiter;
  import arb_defs::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WM = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          m0_ce, m0_we;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_sel;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m0_gnt;
  logic          m1_ce, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_sel;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          m1_gnt;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_sel;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int n_cmp, n_bad;
  // owner: 0 none, 1 cpu, 2 secondary holding lock
  int own, lst, den0, den1, obs0, obs1;
  bit e0, e1;

  data_ram_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WM)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_ce     (m0_ce),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_sel    (m0_sel),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m0_gnt    (m0_gnt),
    .m1_ce     (m1_ce),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_sel    (m1_sel),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_rdata  (m1_rdata),
    .m1_gnt    (m1_gnt),
    .ram_ce    (ram_ce),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_sel   (ram_sel),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] own2st(int o);
    return (o == 1) ? 2'd1 : (o == 2) ? 2'd2 : 2'd0;
  endfunction

  task automatic model_reset();
    own = 0; lst = 1;
    den0 = 0; den1 = 0;
    obs0 = 0; obs1 = 0;
  endtask

  task automatic predict();
    e0 = 0; e1 = 0;
    if (own == 2 && m1_ce && den0 < WM) e1 = 1;
    else if (m0_ce && !m1_ce) e0 = 1;
    else if (m1_ce && !m0_ce) e1 = 1;
    else if (m0_ce && m1_ce) begin
      if (den0 >= WM)            e0 = 1;
      else if (den1 >= WM)       e1 = 1;
      else if (RR && lst == 0)   e1 = 1;
      else                       e0 = 1;
    end
  endtask

  task automatic compare();
    logic [69:0]   er;
    logic [DW-1:0] r0, r1;
    predict();
    er = '0;
    if (e0) er = {1'b1, m0_we, m0_sel, m0_addr, m0_wdata};
    else if (e1) er = {1'b1, m1_we, m1_sel, m1_addr, m1_wdata};
    r0 = e0 ? ram_rdata : '0;
    r1 = e1 ? ram_rdata : '0;
    chk("gnt", 128'({m0_gnt, m1_gnt}), 128'({e0, e1}));
    chk("ram", 128'({ram_ce, ram_we, ram_sel, ram_addr, ram_wdata}),
        128'(er));
    chk("rdata", 128'({m0_rdata, m1_rdata}), 128'({r0, r1}));
    chk("owner", 128'(dut.state), 128'(own2st(own)));
    obs0 = (m0_ce && !m0_gnt) ? obs0 + 1 : 0;
    obs1 = (m1_ce && !m1_gnt) ? obs1 + 1 : 0;
    chk("starve0", 128'(obs0 <= WM), 128'(1));
    chk("starve1", 128'(obs1 <= WM), 128'(1));
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    den0 = (m0_ce && !e0) ? den0 + 1 : 0;
    den1 = (m1_ce && !e1) ? den1 + 1 : 0;
    if (e0 || e1) lst = e1 ? 1 : 0;
    case (own)
      0:       own = e0 ? 1 : (e1 && m1_lock) ? 2 : 0;
      1:       own = e0 ? 1 : 0;
      default: own = (!m1_ce || !m1_lock) ? 0 : (e0 ? 1 : 2);
    endcase
    #1;
  endtask

  task automatic idle_inputs();
    m0_ce = 0; m0_we = 0; m0_addr = '0;
    m0_sel = '0; m0_wdata = '0;
    m1_ce = 0; m1_we = 0; m1_lock = 0;
    m1_addr = '0; m1_sel = '0; m1_wdata = '0;
    ram_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst = 0;
    model_reset();
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic rand_req();
    if (!(m0_ce && !e0)) begin
      m0_ce    = ($urandom_range(0, 3) != 0);
      m0_we    = 1'($urandom_range(0, 1));
      m0_addr  = $urandom;
      m0_sel   = 4'($urandom);
      m0_wdata = $urandom;
    end
    if (!(m1_ce && !e1)) begin
      m1_ce    = ($urandom_range(0, 3) != 0);
      m1_lock  = ($urandom_range(0, 3) != 0);
      m1_we    = 1'($urandom_range(0, 1));
      m1_addr  = $urandom;
      m1_sel   = 4'($urandom);
      m1_wdata = $urandom;
    end
    ram_rdata = $urandom;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 0;
    e0 = 0;
    e1 = 0;
    idle_inputs();
    model_reset();

    // reset state, no requests
    #3;
    settle();
    chk("rst_st", 128'(dut.state), 128'(IDLE));
    @(posedge clk);
    #1 rst = 1;

    // single cpu read
    m0_ce = 1; m0_addr = 32'h10; m0_sel = 4'hf;
    ram_rdata = 32'hDEADBEEF;
    settle();
    chk("rd_gnt", 128'(m0_gnt), 128'(1));
    chk("rd_data0", 128'(m0_rdata), 128'(32'hDEADBEEF));
    chk("rd_data1", 128'(m1_rdata), 128'(0));
    tick();

    // continuous tie from reset
    do_reset();
    m0_ce = 1; m1_ce = 1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("tie_m1", 128'(m1_gnt),
          128'(RR ? (k % 2 == 1) : (k % 5 == 4)));
      tick();
    end

    // locked 3-beat write burst
    do_reset();
    m1_ce = 1; m1_we = 1; m1_lock = 1; m1_sel = 4'hf;
    for (int k = 0; k < 3; k++) begin
      m1_addr  = 32'h100 + 32'(4 * k);
      m1_wdata = $urandom;
      settle();
      chk("burst_gnt", 128'(m1_gnt), 128'(1));
      chk("burst_addr", 128'(ram_addr), 128'(m1_addr));
      tick();
      chk("burst_st", 128'(dut.state), 128'(OWN1));
    end
    m1_ce = 0; m1_lock = 0; m1_we = 0;
    settle();
    tick();
    chk("burst_end", 128'(dut.state), 128'(IDLE));

    // lock break after WAIT_MAX denials
    do_reset();
    m1_ce = 1; m1_lock = 1; m1_addr = 32'h200;
    settle();
    tick();
    m0_ce = 1; m0_addr = 32'h40;
    for (int k = 0; k <= WM; k++) begin
      settle();
      chk("brk_m0", 128'(m0_gnt), 128'(k == WM));
      tick();
    end
    chk("brk_st", 128'(dut.state), 128'(OWN0));
    chk("brk_w0", 128'(dut.w0), 128'(0));

    // async reset in the middle of a lock
    do_reset();
    m1_ce = 1; m1_lock = 1;
    settle();
    tick();
    m0_ce = 1;
    settle();
    tick();
    settle();
    tick();
    #2 rst = 0;
    model_reset();
    #1;
    chk("arst_m1", 128'(m1_gnt), 128'(0));
    chk("arst_m0", 128'(m0_gnt), 128'(1));
    chk("arst_st", 128'(dut.state), 128'(IDLE));
    chk("arst_w0", 128'(dut.w0), 128'(0));
    m0_ce = 0; m1_ce = 0; m1_lock = 0;
    #1;
    chk("arst_ram", 128'({ram_ce, ram_we, ram_sel,
        ram_addr, ram_wdata}), 128'(0));
    chk("arst_gnt", 128'({m0_gnt, m1_gnt}), 128'(0));
    @(posedge clk);
    #1 rst = 1;
    m0_ce = 1; m1_ce = 1;
    settle();
    chk("arst_tie", 128'(m0_gnt), 128'(1));
    tick();

    // random traffic
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      rand_req();
      settle();
      chk("excl", 128'(m0_gnt & m1_gnt), 128'(0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
